// File: rtl/mcac_mc_adpcm_dec.sv
// Multi-channel adaptive-step ADPCM decoder: NCH time-shared channels, shift-add magnitude multiply.
// Optional MCDEC_CHCLR_EN adds a chan_clr[NCH-1:0] synchronous per-channel state clear.
module mcac_mc_adpcm_dec #(
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int CW       = 4,
  parameter int SW       = 16,
  parameter int STEP_MIN = 16,
  parameter int STEP_MAX = 16384
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_in0,
  input  logic           scan_en,
  output logic           scan_out0,
`ifdef MCDEC_CHCLR_EN
  input  logic [NCH-1:0] chan_clr,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [CW-1:0]  in_code,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [SW-1:0]  out_sample,
  output logic           out_sat
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // source holds valid and data stable until then, ready never depends on valid.

  localparam int AW = SW + CW;
  localparam int IW = $clog2(CW);
  localparam logic [IW-1:0]        I_LAST     = IW'(CW - 2);
  localparam logic [SW-1:0]        STEP_MIN_L = SW'(STEP_MIN);
  localparam logic [SW-1:0]        STEP_MAX_L = SW'(STEP_MAX);
  localparam logic signed [AW-1:0] Y_MAX      = AW'((2 ** (SW - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN      = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MUL, UPD, OUT} state_t;

  state_t state, state_nxt;

  logic [SW-1:0]  x_mem    [NCH];
  logic [SW-1:0]  step_mem [NCH];

  logic [CHW-1:0] ch_q;
  logic [CW-1:0]  code_q;
  logic [SW-1:0]  x_q;
  logic [SW-1:0]  step_q;
  logic [AW-1:0]  acc_q;
  logic [IW-1:0]  i_q;

  logic           accept;
  logic           ch_ok;
  logic           in_ready_d;
  logic           out_valid_d;
  logic [CW-2:0]  mag;
  logic           sign;

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] acc_s;
  logic signed [AW-1:0] y_wide;
  logic [SW-1:0]        y;
  logic                 sat;
  logic [SW-1:0]        step_dbl;
  logic [SW-1:0]        step_half;
  logic [SW-1:0]        step_upd;

  wire unused_scan = ^{scan_in0, scan_en};
  assign scan_out0 = 1'b0;

  assign accept = in_valid & in_ready;
  assign ch_ok  = ({1'b0, in_ch} < (CHW + 1)'(NCH));
  assign mag    = code_q[CW-2:0];
  assign sign   = code_q[CW-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ch_ok) state_nxt = MUL;
      MUL:     if (i_q == I_LAST) state_nxt = UPD;
      UPD:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the upcoming state so they change only on edges.
  always_comb begin
    in_ready_d  = (state_nxt == IDLE);
    out_valid_d = (state_nxt == OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Reconstruction and step adaptation, consumed only in UPD.
  always_comb begin
    x_ext     = {{CW{x_q[SW-1]}}, x_q};
    acc_s     = acc_q;
    y_wide    = sign ? (x_ext - acc_s) : (x_ext + acc_s);
    y         = y_wide[SW-1:0];
    sat       = 1'b0;
    if (y_wide > Y_MAX) begin
      y   = Y_MAX[SW-1:0];
      sat = 1'b1;
    end else if (y_wide < Y_MIN) begin
      y   = Y_MIN[SW-1:0];
      sat = 1'b1;
    end
    step_dbl  = {step_q[SW-2:0], 1'b0};
    step_half = {1'b0, step_q[SW-1:1]};
    step_upd  = step_q;
    if (&mag)
      step_upd = (step_dbl > STEP_MAX_L) ? STEP_MAX_L : step_dbl;
    else if (mag == '0)
      step_upd = (step_half < STEP_MIN_L) ? STEP_MIN_L : step_half;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_q       <= '0;
      code_q     <= '0;
      x_q        <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      out_ch     <= '0;
      out_sample <= '0;
      out_sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && ch_ok) begin
            ch_q   <= in_ch;
            code_q <= in_code;
            x_q    <= x_mem[in_ch];
            step_q <= step_mem[in_ch];
            acc_q  <= AW'(step_mem[in_ch] >> 1);
            i_q    <= '0;
          end
        end
        MUL: begin
          // acc starts at step/2, so the sum is step*mag + step/2 exactly.
          if (mag[i_q]) acc_q <= acc_q + (AW'(step_q) << i_q);
          i_q <= i_q + IW'(1);
        end
        UPD: begin
          out_sample <= y;
          out_sat    <= sat;
          out_ch     <= ch_q;
        end
        default: ;
      endcase
    end
  end

  // Per-channel predictor and step storage; a clear overrides a same-edge write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        x_mem[c]    <= '0;
        step_mem[c] <= STEP_MIN_L;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
`ifdef MCDEC_CHCLR_EN
        if (chan_clr[c]) begin
          x_mem[c]    <= '0;
          step_mem[c] <= STEP_MIN_L;
        end else
`endif
        if (state == UPD && ch_q == CHW'(c)) begin
          x_mem[c]    <= y;
          step_mem[c] <= step_upd;
        end
      end
    end
  end

endmodule
